fwd_hazard_unit: RTL

- Control-side counterpart of the execute stage: produces the forwarding selects it consumes, plus pipeline stall and flush controls.
- Keeps a shadow pipeline of register metadata (rs1/rs2/rd, reg_write, mem_read, valid) for the EX, MEM and WB slots, advanced in lockstep with the datapath pipeline registers.
- Detects load-use hazards (stall), applies redirect flushes, and keeps saturating stall/flush performance counters.

---
 rtl/fwd_hazard_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding selects, load-use stall, redirect flush and perf counters
//
// Tracks register metadata for the EX, MEM and WB slots in lockstep with the
// datapath pipeline registers and derives from it:
//   fwd_a_sel/fwd_b_sel : EX operand source, 00 regfile, 01 WB, 10 MEM
//   stall_pc/stall_if_id: hold fetch and IF/ID on a load-use hazard
//   bubble_id_ex        : load a NOP into ID/EX (load-use or redirect)
//   flush_if_id         : invalidate IF/ID on an EX redirect
//   stall_count         : saturating count of load-use stall cycles
//   flush_count         : saturating count of redirect events
// Inputs: clk, rst (sync, active-high), id_* metadata of the ID instruction,
// ex_redirect from the branch unit.
module fwd_hazard_unit #(
    parameter int REG_BITS  = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_BITS-1:0]  id_rs1,
    input  logic [REG_BITS-1:0]  id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_BITS-1:0]  id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 ex_redirect,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 stall_pc,
    output logic                 stall_if_id,
    output logic                 bubble_id_ex,
    output logic                 flush_if_id,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    // EX slot
    logic                ex_valid_q, ex_valid_d;
    logic [REG_BITS-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_BITS-1:0] ex_rs2_q, ex_rs2_d;
    logic                ex_uses_rs1_q, ex_uses_rs1_d;
    logic                ex_uses_rs2_q, ex_uses_rs2_d;
    logic [REG_BITS-1:0] ex_rd_q, ex_rd_d;
    logic                ex_reg_write_q, ex_reg_write_d;
    logic                ex_mem_read_q, ex_mem_read_d;

    // MEM and WB slots
    logic                mem_valid_q, mem_reg_write_q;
    logic [REG_BITS-1:0] mem_rd_q;
    logic                wb_valid_q, wb_reg_write_q;
    logic [REG_BITS-1:0] wb_rd_q;

    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    logic mem_wr_live, wb_wr_live;
    logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
    logic luh;

    // A slot can only be a forwarding source if it really writes a non-x0 register.
    assign mem_wr_live = mem_valid_q & mem_reg_write_q & (mem_rd_q != '0);
    assign wb_wr_live  = wb_valid_q  & wb_reg_write_q  & (wb_rd_q  != '0);

    assign mem_hit_a = ex_valid_q & ex_uses_rs1_q & mem_wr_live & (mem_rd_q == ex_rs1_q);
    assign wb_hit_a  = ex_valid_q & ex_uses_rs1_q & wb_wr_live  & (wb_rd_q  == ex_rs1_q);
    assign mem_hit_b = ex_valid_q & ex_uses_rs2_q & mem_wr_live & (mem_rd_q == ex_rs2_q);
    assign wb_hit_b  = ex_valid_q & ex_uses_rs2_q & wb_wr_live  & (wb_rd_q  == ex_rs2_q);

    // MEM holds the younger result, so it wins over WB.
    assign fwd_a_sel = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
    assign fwd_b_sel = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

    // Only a load sitting in EX forces a stall; once it reaches MEM its data
    // arrives through the WB forwarding path in time.
    assign luh = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                  (id_uses_rs2 & (id_rs2 == ex_rd_q)));

    // Redirect squashes the ID instruction anyway, so stalling would be pointless.
    assign flush_if_id  = ex_redirect;
    assign stall_pc     = luh & ~ex_redirect;
    assign stall_if_id  = luh & ~ex_redirect;
    assign bubble_id_ex = ex_redirect | luh;

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_rs1_d       = '0;
        ex_rs2_d       = '0;
        ex_uses_rs1_d  = 1'b0;
        ex_uses_rs2_d  = 1'b0;
        ex_rd_d        = '0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        if (!bubble_id_ex) begin
            ex_valid_d     = id_valid;
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
            ex_uses_rs1_d  = id_uses_rs1;
            ex_uses_rs2_d  = id_uses_rs2;
            ex_rd_d        = id_rd;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_pc && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
        if (ex_redirect && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_uses_rs1_q   <= 1'b0;
            ex_uses_rs2_q   <= 1'b0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_count_q   <= '0;
            flush_count_q   <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_uses_rs1_q   <= ex_uses_rs1_d;
            ex_uses_rs2_q   <= ex_uses_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            wb_valid_q      <= mem_valid_q;
            wb_rd_q         <= mem_rd_q;
            wb_reg_write_q  <= mem_reg_write_q;
            stall_count_q   <= stall_count_d;
            flush_count_q   <= flush_count_d;
        end
    end

endmodule
